// File: rtl/reg_move_unit.sv
// reg_move_unit: register-file instruction executor (NOP/MOV/MOVI/ADD/SUB/SWAP/CLR) with a valid/ready handshake.
// Optional zero/carry flags are built when REG_MOVE_FLAGS_EN is defined; otherwise flag_z/flag_c are tied to 0.
module reg_move_unit #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        instr_op,
  input  logic [REG_AW-1:0] reg_src,
  input  logic [REG_AW-1:0] reg_dst,
  input  logic [DATA_W-1:0] imm,
  output logic              done,
  output logic              err,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              flag_z,
  output logic              flag_c
);

  localparam int NREGS = 2**REG_AW;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_SWAP2 = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_MOV  = 3'b001,
    OP_MOVI = 3'b010,
    OP_ADD  = 3'b011,
    OP_SUB  = 3'b100,
    OP_SWAP = 3'b101,
    OP_CLR  = 3'b110,
    OP_ILL  = 3'b111
  } op_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [DATA_W-1:0]   r_regs [NREGS];
  op_t                 r_op;
  logic [REG_AW-1:0]   r_src;
  logic [REG_AW-1:0]   r_dst;
  logic [DATA_W-1:0]   r_imm;
  logic [DATA_W-1:0]   r_old_dst;
  logic                r_done;
  logic                r_err;

  logic                w_accept;
  logic                w_wr_en;
  logic [REG_AW-1:0]   w_wr_addr;
  logic [DATA_W-1:0]   w_wr_data;
  logic                w_finish;
  logic                w_illegal;
  logic [DATA_W-1:0]   w_src_val;
  logic [DATA_W-1:0]   w_add;
  logic [DATA_W-1:0]   w_sub;

  assign w_accept  = instr_valid & instr_ready;
  assign w_src_val = r_regs[r_src];
  assign w_sub     = r_old_dst - w_src_val;

`ifdef REG_MOVE_FLAGS_EN
  logic [DATA_W:0] w_add_ext;
  assign w_add_ext = {1'b0, r_old_dst} + {1'b0, w_src_val};
  assign w_add     = w_add_ext[DATA_W-1:0];
`else
  assign w_add     = r_old_dst + w_src_val;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_EXEC;
      S_EXEC:  w_state_nxt = (r_op == OP_SWAP) ? S_SWAP2 : S_IDLE;
      S_SWAP2: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output / write-port decode
  always_comb begin
    instr_ready = 1'b0;
    w_wr_en     = 1'b0;
    w_wr_addr   = r_dst;
    w_wr_data   = '0;
    w_finish    = 1'b0;
    w_illegal   = 1'b0;
    unique case (r_state)
      S_IDLE: instr_ready = ~rst;
      S_EXEC: begin
        w_finish = (r_op != OP_SWAP);
        unique case (r_op)
          OP_MOV:  begin w_wr_en = 1'b1; w_wr_data = w_src_val; end
          OP_MOVI: begin w_wr_en = 1'b1; w_wr_data = r_imm;     end
          OP_ADD:  begin w_wr_en = 1'b1; w_wr_data = w_add;     end
          OP_SUB:  begin w_wr_en = 1'b1; w_wr_data = w_sub;     end
          OP_SWAP: begin w_wr_en = 1'b1; w_wr_data = w_src_val; end
          OP_CLR:  begin w_wr_en = 1'b1; w_wr_data = '0;        end
          OP_ILL:  w_illegal = 1'b1;
          default: ;
        endcase
      end
      // Second half of SWAP: old destination value (latched at accept) goes to src
      S_SWAP2: begin
        w_wr_en   = 1'b1;
        w_wr_addr = r_src;
        w_wr_data = r_old_dst;
        w_finish  = 1'b1;
      end
      default: ;
    endcase
  end

  // Operand latch at accept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op      <= OP_NOP;
      r_src     <= '0;
      r_dst     <= '0;
      r_imm     <= '0;
      r_old_dst <= '0;
    end else if (w_accept) begin
      r_op      <= op_t'(instr_op);
      r_src     <= reg_src;
      r_dst     <= reg_dst;
      r_imm     <= imm;
      r_old_dst <= r_regs[reg_dst];
    end
  end

  // Register file
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[w_wr_addr] <= w_wr_data;
    end
  end

  // Retire pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_done <= w_finish;
      r_err  <= w_illegal;
    end
  end

  assign done     = r_done;
  assign err      = r_err;
  assign dbg_data = r_regs[dbg_addr];

`ifdef REG_MOVE_FLAGS_EN
  logic r_flag_z;
  logic r_flag_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flag_z <= 1'b0;
      r_flag_c <= 1'b0;
    end else if (r_state == S_EXEC) begin
      unique case (r_op)
        OP_MOVI: begin r_flag_z <= (r_imm == '0); r_flag_c <= 1'b0;                   end
        OP_ADD:  begin r_flag_z <= (w_add == '0); r_flag_c <= w_add_ext[DATA_W];      end
        OP_SUB:  begin r_flag_z <= (w_sub == '0); r_flag_c <= (r_old_dst < w_src_val); end
        default: ;
      endcase
    end
  end

  assign flag_z = r_flag_z;
  assign flag_c = r_flag_c;
`else
  assign flag_z = 1'b0;
  assign flag_c = 1'b0;
`endif

endmodule

// File: tb/tb_reg_move_unit.sv
// Self-checking bench for reg_move_unit: directed table, hand-written corner sequences and random instructions.
// Flag expectations follow REG_MOVE_FLAGS_EN as defined for the build.
`timescale 1ns/1ps
module tb_reg_move_unit;

  localparam int DATA_W = 8;
  localparam int REG_AW = 3;
  localparam int NREGS  = 8;

  logic              clk;
  logic              rst;
  logic              instr_valid;
  logic              instr_ready;
  logic [2:0]        instr_op;
  logic [REG_AW-1:0] reg_src;
  logic [REG_AW-1:0] reg_dst;
  logic [DATA_W-1:0] imm;
  logic              done;
  logic              err;
  logic [REG_AW-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic              flag_z;
  logic              flag_c;

  reg_move_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .reg_src(reg_src), .reg_dst(reg_dst), .imm(imm),
    .done(done), .err(err), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .flag_z(flag_z), .flag_c(flag_c)
  );

  initial begin
    clk = 1'b0;
    forever #20 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  int checks   = 0;
  int failures = 0;

  // Reference model: plain arrays and integer arithmetic
  int m_regs [NREGS];
  int m_z = 0;
  int m_c = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_regs[i] = 0;
    m_z = 0;
    m_c = 0;
  endtask

  task automatic model_exec(input int op, input int s, input int d, input int im);
    int t;
    case (op)
      1: m_regs[d] = m_regs[s];
      2: begin m_regs[d] = im; m_z = (im == 0); m_c = 0; end
      3: begin
        t = m_regs[d] + m_regs[s];
        m_c = (t > 255);
        m_regs[d] = t % 256;
        m_z = (m_regs[d] == 0);
      end
      4: begin
        m_c = (m_regs[d] < m_regs[s]);
        m_regs[d] = (m_regs[d] - m_regs[s] + 256) % 256;
        m_z = (m_regs[d] == 0);
      end
      5: begin t = m_regs[d]; m_regs[d] = m_regs[s]; m_regs[s] = t; end
      6: m_regs[d] = 0;
      default: ;
    endcase
  endtask

  task automatic check_all(input string tag);
    for (int i = 0; i < NREGS; i++) begin
      dbg_addr = REG_AW'(i);
      #1;
      chk($sformatf("%s_r%0d", tag, i), 32'(dbg_data), 32'(m_regs[i]));
    end
`ifdef REG_MOVE_FLAGS_EN
    chk({tag, "_flag_z"}, 32'(flag_z), 32'(m_z));
    chk({tag, "_flag_c"}, 32'(flag_c), 32'(m_c));
`else
    chk({tag, "_flag_z"}, 32'(flag_z), 32'd0);
    chk({tag, "_flag_c"}, 32'(flag_c), 32'd0);
`endif
  endtask

  task automatic drive(input int op, input int s, input int d, input int im);
    instr_op = 3'(op);
    reg_src  = REG_AW'(s);
    reg_dst  = REG_AW'(d);
    imm      = DATA_W'(im);
  endtask

  // Issue one instruction and check handshake timing, done/err pulse and all registers
  task automatic issue(input int op, input int s, input int d, input int im, input string tag);
    int n;
    n = 0;
    while (!instr_ready && n < 10) begin @(negedge clk); n++; end
    chk({tag, "_ready_wait"}, 32'(instr_ready), 32'd1);
    drive(op, s, d, im);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    chk({tag, "_ready_exec"}, 32'(instr_ready), 32'd0);
    chk({tag, "_done_exec"}, 32'(done), 32'd0);
    if (op == 5) begin
      @(negedge clk);
      chk({tag, "_ready_swap2"}, 32'(instr_ready), 32'd0);
      chk({tag, "_done_swap2"}, 32'(done), 32'd0);
    end
    @(negedge clk);
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_err"}, 32'(err), 32'(op == 7));
    chk({tag, "_ready_ret"}, 32'(instr_ready), 32'd1);
    model_exec(op, s, d, im);
    check_all(tag);
  endtask

  typedef struct {
    int op; int src; int dst; int imm;
    int exp_val; int exp_z; int exp_c;
  } vec_t;

  vec_t vt [12];

  initial begin
    rst = 1'b1; instr_valid = 1'b0; dbg_addr = '0;
    drive(0, 0, 0, 0);
    model_reset();

    vt[0]  = '{2, 0, 3, 'hA5, 'hA5, 0, 0};
    vt[1]  = '{1, 3, 5, 0,    'hA5, 0, 0};
    vt[2]  = '{2, 0, 1, 'hF0, 'hF0, 0, 0};
    vt[3]  = '{2, 0, 2, 'h20, 'h20, 0, 0};
    vt[4]  = '{3, 2, 1, 0,    'h10, 0, 1};
    vt[5]  = '{4, 2, 2, 0,    'h00, 1, 0};
    vt[6]  = '{2, 0, 4, 'h5A, 'h5A, 0, 0};
    vt[7]  = '{7, 1, 4, 'h33, 'h5A, 0, 0};
    vt[8]  = '{3, 4, 4, 0,    'hB4, 0, 0};
    vt[9]  = '{4, 4, 0, 0,    'h4C, 0, 1};
    vt[10] = '{6, 0, 4, 0,    'h00, 0, 1};
    vt[11] = '{0, 1, 0, 0,    'h4C, 0, 1};

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready_low", 32'(instr_ready), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_ready", 32'(instr_ready), 32'd1);
    chk("post_rst_err", 32'(err), 32'd0);
    check_all("post_rst");

    // Directed table
    for (int i = 0; i < 12; i++) begin
      issue(vt[i].op, vt[i].src, vt[i].dst, vt[i].imm, $sformatf("vec%0d", i));
      dbg_addr = REG_AW'(vt[i].dst);
      #1;
      chk($sformatf("vec%0d_dst", i), 32'(dbg_data), 32'(vt[i].exp_val));
`ifdef REG_MOVE_FLAGS_EN
      chk($sformatf("vec%0d_z", i), 32'(flag_z), 32'(vt[i].exp_z));
      chk($sformatf("vec%0d_c", i), 32'(flag_c), 32'(vt[i].exp_c));
`endif
    end

    // SWAP with instr_valid held high; next instruction accepted in the done cycle
    issue(2, 0, 1, 'h11, "sw_set1");
    issue(2, 0, 2, 'h22, "sw_set2");
    drive(5, 2, 1, 0);
    instr_valid = 1'b1;
    @(negedge clk);
    chk("hold_ready_c1", 32'(instr_ready), 32'd0);
    @(negedge clk);
    chk("hold_ready_c2", 32'(instr_ready), 32'd0);
    chk("hold_done_c2", 32'(done), 32'd0);
    @(negedge clk);
    chk("hold_ready_c3", 32'(instr_ready), 32'd1);
    chk("hold_done_c3", 32'(done), 32'd1);
    model_exec(5, 2, 1, 0);
    dbg_addr = 3'd1; #1 chk("hold_r1", 32'(dbg_data), 32'h22);
    dbg_addr = 3'd2; #1 chk("hold_r2", 32'(dbg_data), 32'h11);
    drive(2, 0, 6, 'h77);
    @(negedge clk);
    chk("b2b_accepted", 32'(instr_ready), 32'd0);
    chk("b2b_done_low", 32'(done), 32'd0);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("b2b_done", 32'(done), 32'd1);
    model_exec(2, 0, 6, 'h77);
    check_all("b2b");

    // Same-index SWAP keeps data and takes 3 cycles
    issue(5, 6, 6, 0, "swap_same");

    // Asynchronous reset during SWAP2
    drive(5, 1, 2, 0);
    instr_valid = 1'b1;
    @(negedge clk);
    instr_valid = 1'b0;
    @(negedge clk);
    chk("abort_in_swap2", 32'(instr_ready), 32'd0);
    #3 rst = 1'b1;
    #1;
    model_reset();
    chk("abort_ready", 32'(instr_ready), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    check_all("abort");
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done), 32'd0);
      chk("abort_idle_ready", 32'(instr_ready), 32'd1);
    end
    check_all("abort_after");
    issue(2, 0, 0, 'h01, "post_abort_movi");

    // Random instructions against the model
    for (int i = 0; i < 200; i++) begin
      issue(int'($urandom_range(0, 7)), int'($urandom_range(0, NREGS-1)),
            int'($urandom_range(0, NREGS-1)), int'($urandom_range(0, 255)),
            $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
